// File: rtl/input_debounce_capture.sv
// input_debounce_capture: 2-FF sync and per-bit debounce of buttons/switches, with an Avalon-MM slave.
// Press edge capture, W1C, irq mask and irq are built only when INPUT_CAPTURE_IRQ_EN is defined.
module input_debounce_capture #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int N_BTN = 4,
  parameter int N_SW = 10
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [N_BTN-1:0] button_raw,
  input  logic [N_SW-1:0]  switch_raw,
  output logic [N_BTN-1:0] button_clean,
  output logic [N_SW-1:0]  switch_clean,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);
  localparam int N = N_BTN + N_SW;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N-1:0] RST_VAL = {{N_BTN{1'b1}}, {N_SW{1'b0}}};
  logic [N-1:0] sync1_q, sync2_q, clean_q, clean_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [N_BTN-1:0] rd_edge, rd_mask;
  logic [31:0] rdata_d, readdata_q;
  logic unused_ok;
  assign unused_ok = ^{avs_write, avs_writedata};
  // buttons occupy the upper bits of the combined vector
  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_MAX) clean_d[i] = sync2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
      clean_q <= RST_VAL;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= {button_raw, switch_raw};
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign button_clean = clean_q[N-1:N_SW];
  assign switch_clean = clean_q[N_SW-1:0];
`ifdef INPUT_CAPTURE_IRQ_EN
  logic [N_BTN-1:0] prev_q, edge_q, edge_d, mask_q, mask_d, w1c;
  // prev_q resets high so reset release never looks like a press
  always_comb begin
    w1c = (avs_write && avs_address == 2'd2) ? avs_writedata[N_BTN-1:0] : '0;
    edge_d = (edge_q & ~w1c) | (prev_q & ~button_clean);
    mask_d = (avs_write && avs_address == 2'd3) ? avs_writedata[N_BTN-1:0] : mask_q;
  end
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      prev_q <= '1;
      edge_q <= '0;
      mask_q <= '0;
    end else begin
      prev_q <= button_clean;
      edge_q <= edge_d;
      mask_q <= mask_d;
    end
  end
  assign rd_edge = edge_q;
  assign rd_mask = mask_q;
  assign irq = |(edge_q & mask_q);
`else
  assign rd_edge = '0;
  assign rd_mask = '0;
  assign irq = 1'b0;
`endif
  always_comb begin
    rdata_d = avs_address == 2'd0 ? 32'(button_clean) :
              avs_address == 2'd1 ? 32'(switch_clean) :
              avs_address == 2'd2 ? 32'(rd_edge) : 32'(rd_mask);
  end
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) readdata_q <= '0;
    else if (avs_read) readdata_q <= rdata_d;
  end
  assign avs_readdata = readdata_q;
endmodule

// File: doc/input_debounce_capture.md
# input_debounce_capture

Conditions the board's raw push-buttons and slide switches before they reach the Nios system's `button_external_connection_export` and `switch_external_connection_export` inputs. The block provides 2-FF synchronisation and per-bit debouncing, and exposes clean levels to the Nios PIOs. It also implements a small Avalon-MM slave with button press edge capture and an interrupt. It sits at the top level between the board pins and the `nios` instance, on the same clock.

## Interface
- `DEBOUNCE_CYCLES`, 50000, cycles a changed synced input must be stable before the clean output follows (1 ms at 50 MHz); minimum 2.
- `N_BTN`, 4, number of buttons (active-low on board).
- `N_SW`, 10, number of switches.

- `clk_clk`  in  1  system clock.
- `reset_reset`  in  1  asynchronous, active-high reset.
- `button_raw`  in  N_BTN  raw key pins, asynchronous, 0 = pressed.
- `switch_raw`  in  N_SW  raw switch pins, asynchronous.
- `button_clean`  out  N_BTN  debounced buttons, same polarity; to the Nios button PIO.
- `switch_clean`  out  N_SW  debounced switches; to the Nios switch PIO.
- `avs_address`  in  2  word address.
- `avs_read`  in  1  read strobe.
- `avs_write`  in  1  write strobe.
- `avs_writedata`  in  32  write data.
- `avs_readdata`  out  32  read data, registered.
- `irq`  out  1  level interrupt, active-high.

## Operation
- **Sync:** each raw bit passes through 2 flops. Reset values: buttons 1, switches 0.
- **Debounce:** each bit has its own counter of width `$clog2(DEBOUNCE_CYCLES)`.
  - If synced == clean, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while synced != clean, clean <= synced and the counter clears.
  - Any bounce back to the clean value restarts the count from 0.
- **Edge capture:** `edge[i]` sets when `button_clean[i]` goes 1 -> 0 (press). Releases are not captured.
- **Register map** (`avs_readdata` is updated only on `avs_read`, otherwise held):
  - 0: `{0, button_clean}`, read-only.
  - 1: `{0, switch_clean}`, read-only.
  - 2: `{0, edge}`. Write-1-to-clear per bit.
  - 3: `{0, irq_mask}`, read/write, N_BTN bits.
- **Unused bits and writes:** unused readdata bits read 0. Writes to addresses 0 and 1 are ignored.
- **irq:** `irq = |(edge & irq_mask)`, combinational from registers only.
- **Simultaneous events:**
  - A new press edge and a W1C of the same bit in the same cycle leave the bit set (set wins).
  - A read in the same cycle returns the pre-update value.
- **Reset (at any time, including mid-debounce):**
  - Counters clear.
  - `button_clean` = all 1, `switch_clean` = 0.
  - `edge` = 0, `irq_mask` = 0.
  - `avs_readdata` = 0, `irq` = 0.
  - No edge is generated on reset release.

## Timing
- **Input-to-clean latency:** a raw change stable from cycle T appears on the clean output at T+2+DEBOUNCE_CYCLES (±1 cycle of sync sampling).
- **Glitch rejection:** glitches shorter than DEBOUNCE_CYCLES-1 synced cycles never reach the clean outputs.
- **Edge capture:** an `edge` bit is set the cycle after `button_clean` falls. `irq` rises in that same cycle if the bit is unmasked.
- **Read latency:** 1 cycle; `avs_readdata` is valid the cycle after `avs_read`. No wait states.
- **Write timing:** a write takes effect at the clock edge where `avs_write` = 1. `irq` deasserts in the following cycle after a W1C that clears the last pending unmasked bit.
- **Counter saturation:** a counter never exceeds DEBOUNCE_CYCLES-1.

## Configuration
- **`INPUT_CAPTURE_IRQ_EN` defined:** `edge` and `irq_mask` registers and the `irq` output behave as above.
- **Not defined:** edge-capture and mask logic is not built.
  - `irq` is tied 0.
  - Addresses 2 and 3 read 0 and ignore writes.
  - Debounce outputs and addresses 0 and 1 are unchanged.

## Test plan
- **Reset values:** DEBOUNCE_CYCLES=4; assert `reset_reset` with `button_raw`=4'b0000 -> `button_clean`=4'hF, `edge`=0, `irq`=0 during and right after reset; `button_clean` falls to 0 only after the debounce delay, setting `edge`=4'hF.
- **Bounce rejection:** DEBOUNCE_CYCLES=4; toggle `button_raw[0]` low for 2 cycles then high, repeated 5 times -> `button_clean[0]` stays 1, `edge`=0.
- **Press and interrupt:** write address 3 = 4'b0001; hold `button_raw[0]`=0 -> `button_clean[0]` falls about 6 cycles later, `edge[0]`=1, `irq`=1; read address 2 -> readdata 32'h1 one cycle after the read.
- **W1C vs. new edge:** write address 2 = 32'h1 in the same cycle a new `button_clean[0]` fall occurs -> `edge[0]` remains 1 and `irq` stays high. A later W1C with no new edge -> `irq`=0 the next cycle.
- **Switch path:** `switch_raw`=10'h2A5 held -> `switch_clean`=10'h2A5 after 2+DEBOUNCE_CYCLES cycles; read address 1 -> 32'h2A5; write address 1 -> no change.
- **Reset mid-debounce:** assert `reset_reset` asynchronously while a counter is at 2 -> all outputs return to reset values immediately, and the count restarts from 0 after release.
